// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the MEM-stage load/store path: op encodings, sequencer
// states, the full-word DataMem mask and the alignment rule.
package cpu_mem_pkg;

    localparam int ADDR_WIDTH_DEF = 12;
    localparam int DATA_WIDTH_DEF = 32;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_MRG  = 2'd2,
        ST_WR   = 2'd3
    } state_e;

    function automatic logic is_load(input op_e op);
        return (op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW});
    endfunction

    function automatic logic is_misaligned(input op_e op, input logic [1:0] lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: return lo[0];
            OP_LW, OP_SW:         return |lo;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: pulls a byte/half out of a word with sign or zero
// extension, and splices a store byte/half into a word for read-modify-write.
module lsu_lane_align
    import cpu_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    input  logic [1:0]  lane,
    input  op_e         op,
    output logic [31:0] ext,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? word[31:16] : word[15:0];

        case (op)
            OP_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  ext = {24'b0, byte_sel};
            OP_LH:   ext = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  ext = {16'b0, half_sel};
            default: ext = word;
        endcase

        merged = word;
        if (op == OP_SB) begin
            merged[{lane, 3'b000} +: 8] = wdata[7:0];
        end else if (op == OP_SH) begin
            if (lane[1]) merged[31:16] = wdata;
            else         merged[15:0]  = wdata;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store sequencer in front of a word-only DataMem; sub-word
// stores are done as read-modify-write, bad addresses are rejected unexecuted.
module load_store_unit
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err,
    output logic                  mem_ce,
    output logic                  mem_memRr,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wtData,
    output logic [3:0]            mem_w_mask,
    output logic [3:0]            mem_r_mask,
    input  logic [DATA_WIDTH-1:0] mem_rdData
);

    state_e      state;
    op_e         op_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic [31:0] ext;
    logic [31:0] merged;
    op_e         op_in;
    logic        req_err;

    // Handshake: a request transfers on any rising edge where req_valid && req_ready;
    // the requester holds it until then. Responses are a single-cycle pulse, never stalled.
    assign req_ready  = (state == ST_IDLE);
    assign mem_w_mask = MASK_WORD;
    assign mem_r_mask = MASK_WORD;

    assign op_in   = op_e'(req_op);
    assign req_err = is_misaligned(op_in, req_addr[1:0]) || (|req_addr[31:ADDR_WIDTH]);

    lsu_lane_align u_align (
        .word   (mem_rdData),
        .wdata  (wdata_q),
        .lane   (lane_q),
        .op     (op_q),
        .ext    (ext),
        .merged (merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= OP_LB;
            lane_q     <= 2'b00;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            mem_ce     <= 1'b0;
            mem_memRr  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wtData <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= op_in;
                        lane_q  <= req_addr[1:0];
                        wdata_q <= req_wdata[15:0];
                        if (req_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= '0;
                        end else begin
                            mem_ce   <= 1'b1;
                            mem_addr <= {req_addr[31:2], 2'b00};
                            if (is_load(op_in)) begin
                                state     <= ST_RD;
                                mem_memRr <= 1'b1;
                            end else if (op_in == OP_SW) begin
                                state      <= ST_WR;
                                mem_we     <= 1'b1;
                                mem_wtData <= req_wdata;
                            end else begin
                                state     <= ST_MRG;
                                mem_memRr <= 1'b1;
                            end
                        end
                    end
                end
                ST_RD: begin
                    state      <= ST_IDLE;
                    mem_ce     <= 1'b0;
                    mem_memRr  <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_data  <= ext;
                end
                ST_MRG: begin
                    // Read word is on mem_rdData this cycle; the merged word is written next.
                    state      <= ST_WR;
                    mem_memRr  <= 1'b0;
                    mem_we     <= 1'b1;
                    mem_wtData <= merged;
                end
                ST_WR: begin
                    state      <= ST_IDLE;
                    mem_ce     <= 1'b0;
                    mem_we     <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_data  <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural DataMem model: checks
// reset values, load extension, RMW stores, error rejection and reset abort.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        mem_ce;
    logic        mem_memRr;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wtData;
    logic [3:0]  mem_w_mask;
    logic [3:0]  mem_r_mask;
    logic [31:0] mem_rdData;

    logic [31:0] mem [0:1023];
    logic        pre_en;
    logic [9:0]  pre_idx;
    logic [31:0] pre_data;

    int checks;
    int failures;

    localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3,
                           LW = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .mem_ce     (mem_ce),
        .mem_memRr  (mem_memRr),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wtData (mem_wtData),
        .mem_w_mask (mem_w_mask),
        .mem_r_mask (mem_r_mask),
        .mem_rdData (mem_rdData)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DataMem model: combinational read, write commits on the rising edge
    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_data;
        else if (mem_ce && mem_we) mem[mem_addr[11:2]] <= mem_wtData;
    end
    assign mem_rdData = mem[mem_addr[11:2]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = idx; pre_data = data;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Called on a negedge with the unit idle; returns on the negedge of the response cycle.
    task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] data, output logic err,
                          output int lat, output int we_cnt, output int ce_cnt);
        check("req_ready_before_issue", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1; we_cnt = 0; ce_cnt = 0;
        while (!resp_valid && lat < 8) begin
            ce_cnt += int'(mem_ce);
            we_cnt += int'(mem_we);
            @(negedge clk);
            lat++;
        end
        ce_cnt += int'(mem_ce);
        we_cnt += int'(mem_we);
        data = resp_data;
        err  = resp_err;
    endtask

    task automatic load_chk(input string tag, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] exp_data);
        logic [31:0] d; logic e; int lat, wc, cc;
        do_req(op, addr, 32'h0, d, e, lat, wc, cc);
        check({tag, "_data"}, d, exp_data);
        check({tag, "_err"}, {31'b0, e}, 32'd0);
        check({tag, "_lat"}, 32'(lat), 32'd2);
        check({tag, "_we"}, 32'(wc), 32'd0);
    endtask

    task automatic store_chk(input string tag, input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] wdata, input int exp_lat);
        logic [31:0] d; logic e; int lat, wc, cc;
        do_req(op, addr, wdata, d, e, lat, wc, cc);
        check({tag, "_err"}, {31'b0, e}, 32'd0);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_we_cycles"}, 32'(wc), 32'd1);
    endtask

    task automatic err_chk(input string tag, input logic [2:0] op, input logic [31:0] addr);
        logic [31:0] d; logic e; int lat, wc, cc;
        do_req(op, addr, 32'h5555_5555, d, e, lat, wc, cc);
        check({tag, "_err"}, {31'b0, e}, 32'd1);
        check({tag, "_data"}, d, 32'h0);
        check({tag, "_lat"}, 32'(lat), 32'd1);
        check({tag, "_ce"}, 32'(cc), 32'd0);
    endtask

    initial begin
        int seen;
        checks = 0; failures = 0;
        rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = '0; req_wdata = '0;
        pre_en = 1'b0; pre_idx = '0; pre_data = '0;

        // preload while held in reset
        preload(10'd3, 32'h7FFF_FFFF);
        preload(10'd4, 32'h8000_0000);
        preload(10'd6, 32'hFFFF_FFFE);
        preload(10'd8, 32'h0000_0000);

        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_ce_rr_we", {29'b0, mem_ce, mem_memRr, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wtdata", mem_wtData, 32'h0);
        check("masks", {24'b0, mem_w_mask, mem_r_mask}, 32'h0000_00FF);

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // loads of 0x80000000 at 0x10
        load_chk("lw_10", LW, 32'h10, 32'h8000_0000);
        load_chk("lb_13", LB, 32'h13, 32'hFFFF_FF80);
        load_chk("lbu_13", LBU, 32'h13, 32'h0000_0080);
        load_chk("lh_12", LH, 32'h12, 32'hFFFF_8000);
        load_chk("lhu_10", LHU, 32'h10, 32'h0000_0000);

        // byte RMW store
        store_chk("sb_0d", SB, 32'h0D, 32'h0000_00AB, 3);
        check("sb_0d_mem", mem[3], 32'h7FFF_ABFF);
        load_chk("lbu_0d", LBU, 32'h0D, 32'h0000_00AB);

        // rejected accesses
        err_chk("lw_0e", LW, 32'h0E);
        err_chk("sh_0f", SH, 32'h0F);
        err_chk("lw_1000", LW, 32'h1000);
        check("err_mem3", mem[3], 32'h7FFF_ABFF);
        check("err_mem0_untouched", mem[4], 32'h8000_0000);

        // SW then back-to-back loads
        store_chk("sw_20", SW, 32'h20, 32'hDEAD_BEEF, 2);
        load_chk("lw_20", LW, 32'h20, 32'hDEAD_BEEF);
        load_chk("lb_21", LB, 32'h21, 32'hFFFF_FFBE);
        load_chk("lhu_22", LHU, 32'h22, 32'h0000_DEAD);

        // halfword RMW store into upper lane
        store_chk("sh_0e", SH, 32'h0E, 32'h0000_1234, 3);
        check("sh_0e_mem", mem[3], 32'h1234_ABFF);

        // reset while in MRG for SH 0x18
        @(negedge clk);
        req_valid = 1'b1; req_op = SH; req_addr = 32'h18; req_wdata = 32'h0000_1234;
        @(negedge clk);
        req_valid = 1'b0;
        check("mrg_ce", {30'b0, mem_ce, mem_memRr}, 32'd3);
        rst = 1'b1;
        #1;
        check("abort_we", {31'b0, mem_we}, 32'd0);
        seen = 0;
        @(negedge clk);
        seen += int'(resp_valid);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen += int'(resp_valid) + int'(mem_we);
        end
        check("abort_no_resp", 32'(seen), 32'd0);
        check("abort_ready", {31'b0, req_ready}, 32'd1);
        check("abort_mem", mem[6], 32'hFFFF_FFFE);
        load_chk("lw_18_after", LW, 32'h18, 32'hFFFF_FFFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
